// File: rtl/adder_pipe_n_if.sv
// Handshake/data bundle for adder_pipe_n: operand side (in_*) and result side (out_*).
// ADDER_PIPE_SUB_EN adds the in_sub operand-side signal.
interface adder_pipe_n_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             in_carry;
`ifdef ADDER_PIPE_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;

`ifdef ADDER_PIPE_SUB_EN
  modport master (
    output in_valid, in_1, in_2, in_carry, in_sub, out_ready,
    input  in_ready, out_valid, out_sum
  );
  modport slave (
    input  in_valid, in_1, in_2, in_carry, in_sub, out_ready,
    output in_ready, out_valid, out_sum
  );
`else
  modport master (
    output in_valid, in_1, in_2, in_carry, out_ready,
    input  in_ready, out_valid, out_sum
  );
  modport slave (
    input  in_valid, in_1, in_2, in_carry, out_ready,
    output in_ready, out_valid, out_sum
  );
`endif
endinterface

// File: rtl/adder_pipe_n.sv
// STAGES-deep pipelined WIDTH-bit adder; one CHUNK of the carry chain per stage, global stall.
// Optional subtract mode (in_sub) is built when ADDER_PIPE_SUB_EN is defined.
module adder_pipe_n #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  adder_pipe_n_if.slave bus
);
  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  logic             adv;

  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic             valid_q [STAGES];

  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_d [STAGES];
  logic             valid_d [STAGES];

  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic [WIDTH-1:0] s_in    [STAGES];
  logic             c_in    [STAGES];
  logic             v_in    [STAGES];
  logic [CHUNK:0]   part    [STAGES];

  always_comb begin
    adv = bus.out_ready || !valid_q[LAST];
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_sum   = {carry_q[LAST], sum_q[LAST]};

  // Subtraction folds into the add at entry (invert B, force carry-in), so later
  // stages never need to know the operation.
  always_comb begin
    a_in = '{default: '0};
    b_in = '{default: '0};
    s_in = '{default: '0};
    c_in = '{default: 1'b0};
    v_in = '{default: 1'b0};
    a_in[0] = bus.in_1;
`ifdef ADDER_PIPE_SUB_EN
    b_in[0] = bus.in_sub ? ~bus.in_2 : bus.in_2;
    c_in[0] = bus.in_sub ? 1'b1 : bus.in_carry;
`else
    b_in[0] = bus.in_2;
    c_in[0] = bus.in_carry;
`endif
    v_in[0] = bus.in_valid && adv;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = sum_q[k-1];
      c_in[k] = carry_q[k-1];
      v_in[k] = valid_q[k-1];
    end
  end

  // Operand bits already consumed are zeroed so they do not travel further.
  always_comb begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] keep;
    ones    = '1;
    keep    = '0;
    part    = '{default: '0};
    a_d     = '{default: '0};
    b_d     = '{default: '0};
    sum_d   = '{default: '0};
    carry_d = '{default: 1'b0};
    valid_d = '{default: 1'b0};
    for (int unsigned k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_in[k]};
      sum_d[k] = s_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      carry_d[k] = part[k][CHUNK];
      keep       = ones << ((k + 1) * CHUNK);
      a_d[k]     = a_in[k] & keep;
      b_d[k]     = b_in[k] & keep;
      valid_d[k] = v_in[k];
    end
  end

  // The output stage only loads on a valid slot, so out_sum holds through bubbles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        if ((k != LAST) || valid_d[k]) begin
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe_n.sv
// Bench for adder_pipe_n: a 32-bit/2-stage and a 64-bit/4-stage instance against a queue model.
// Define ADDER_PIPE_SUB_EN for both RTL and bench to cover subtract mode.
module tb_adder_pipe_n;
  localparam int unsigned STG [2] = '{2, 4};
  localparam int unsigned WID [2] = '{32, 64};

  typedef struct {
    logic [64:0] exp;
    int unsigned t;
    bit          st;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  string nm [2] = '{"w32", "w64"};
  bit sub_drv [2] = '{1'b0, 1'b0};
  sb_t sb [2][$];
  logic [64:0] got [2][$];

  adder_pipe_n_if #(.WIDTH(32)) bus32 ();
  adder_pipe_n_if #(.WIDTH(64)) bus64 ();

  adder_pipe_n #(.WIDTH(32), .STAGES(2)) u_dut32 (.clock(clock), .reset(reset), .bus(bus32));
  adder_pipe_n #(.WIDTH(64), .STAGES(4)) u_dut64 (.clock(clock), .reset(reset), .bus(bus64));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [64:0] got_v, input logic [64:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [64:0] model(input int unsigned w, input logic [63:0] a, b,
                                        input bit c, input bit s);
    logic [64:0] mask;
    logic [64:0] aa;
    logic [64:0] bb;
    mask = (w == 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
    aa   = {1'b0, a} & mask;
    bb   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    return aa + bb + ((s || c) ? 65'd1 : 65'd0);
  endfunction

  function automatic bit f_ov(input int d);
    return (d == 0) ? bus32.out_valid : bus64.out_valid;
  endfunction
  function automatic bit f_ir(input int d);
    return (d == 0) ? bus32.in_ready : bus64.in_ready;
  endfunction
  function automatic bit f_iv(input int d);
    return (d == 0) ? bus32.in_valid : bus64.in_valid;
  endfunction
  function automatic bit f_or(input int d);
    return (d == 0) ? bus32.out_ready : bus64.out_ready;
  endfunction
  function automatic bit f_ic(input int d);
    return (d == 0) ? bus32.in_carry : bus64.in_carry;
  endfunction
  function automatic logic [64:0] f_sum(input int d);
    return (d == 0) ? {32'b0, bus32.out_sum} : bus64.out_sum;
  endfunction
  function automatic logic [63:0] f_a(input int d);
    return (d == 0) ? {32'b0, bus32.in_1} : bus64.in_1;
  endfunction
  function automatic logic [63:0] f_b(input int d);
    return (d == 0) ? {32'b0, bus32.in_2} : bus64.in_2;
  endfunction

  task automatic drive(input int d, input bit v, input logic [63:0] a, b, input bit c, input bit s);
    sub_drv[d] = s;
    if (d == 0) begin
      bus32.in_valid = v; bus32.in_1 = a[31:0]; bus32.in_2 = b[31:0]; bus32.in_carry = c;
`ifdef ADDER_PIPE_SUB_EN
      bus32.in_sub = s;
`endif
    end else begin
      bus64.in_valid = v; bus64.in_1 = a; bus64.in_2 = b; bus64.in_carry = c;
`ifdef ADDER_PIPE_SUB_EN
      bus64.in_sub = s;
`endif
    end
  endtask

  task automatic set_or(input int d, input bit r);
    if (d == 0) bus32.out_ready = r;
    else        bus64.out_ready = r;
  endtask

  // Scoreboard: sampled mid-cycle; the handshakes seen here complete at the next rising edge.
  always @(negedge clock) begin
    sb_t e;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        sb[d].delete();
      end else begin
        if (f_ov(d) && f_or(d)) begin
          if (sb[d].size() == 0) begin
            check({nm[d], ".spurious_valid"}, f_ov(d), 0);
          end else begin
            e = sb[d].pop_front();
            got[d].push_back(f_sum(d));
            check({nm[d], ".sum"}, f_sum(d), e.exp);
            if (!e.st) check({nm[d], ".latency_edge"}, cyc, e.t + STG[d] - 1);
          end
        end else if (sb[d].size() == 0) begin
          check({nm[d], ".idle_valid"}, f_ov(d), 0);
        end
        if (!f_ir(d)) for (int i = 0; i < sb[d].size(); i++) sb[d][i].st = 1'b1;
        if (f_iv(d) && f_ir(d)) begin
          e.exp = model(WID[d], f_a(d), f_b(d), f_ic(d), sub_drv[d]);
          e.t   = cyc + 1;
          e.st  = 1'b0;
          sb[d].push_back(e);
        end
      end
    end
  end

  task automatic send(input int d, input logic [63:0] a, b, input bit c, input bit s);
    int unsigned n;
    n = 0;
    drive(d, 1'b1, a, b, c, s);
    @(negedge clock);
    while (!f_ir(d) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!f_ir(d)) check({nm[d], ".send_timeout"}, f_ir(d), 1);
    @(posedge clock); #1;
    drive(d, 1'b0, a, b, c, s);
  endtask

  task automatic drain(input int d);
    int unsigned n;
    n = 0;
    while ((sb[d].size() != 0 || f_ov(d)) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    check({nm[d], ".drain_left"}, sb[d].size(), 0);
  endtask

  task automatic lat_test(input int d);
    drive(d, 1'b1, 64'd3827, 64'd9273, 1'b0, 1'b0);
    @(posedge clock); #1;
    drive(d, 1'b1, 64'd13442, 64'd10042, 1'b0, 1'b0);
    @(posedge clock); #1;
    drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (STG[d] - 2) @(posedge clock);
    @(negedge clock);
    check({nm[d], ".lat_valid1"}, f_ov(d), 1);
    check({nm[d], ".lat_sum1"}, f_sum(d), 65'd13100);
    @(negedge clock);
    check({nm[d], ".lat_valid2"}, f_ov(d), 1);
    check({nm[d], ".lat_sum2"}, f_sum(d), 65'd23484);
    @(posedge clock); #1;
    drain(d);
  endtask

  logic [63:0] ca [2][4] = '{
    '{64'h0000FFFF, 64'h0FFFFFFF, 64'hFFFF0000, 64'hFFFFFFFF},
    '{64'h000000000000FFFF, 64'h0FFFFFFFFFFFFFFF, 64'hFFFF0000FFFF0000, 64'hFFFFFFFFFFFFFFFF}};
  logic [63:0] cb [2][4] = '{
    '{64'h1, 64'hFFFFFFEF, 64'hFFFF0000, 64'h0},
    '{64'h1, 64'hFFFFFFFFFFFFFFEF, 64'hFFFF0000FFFF0000, 64'h0}};
  bit cc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [64:0] ce [2][4] = '{
    '{65'h0_00010000, 65'h1_0FFFFFEE, 65'h1_FFFE0000, 65'h1_00000000},
    '{65'h0_0000000000010000, 65'h1_0FFFFFFFFFFFFFEE, 65'h1_FFFE0001FFFE0000,
      65'h1_0000000000000000}};

  task automatic carry_test(input int d);
    int unsigned base;
    base = got[d].size();
    for (int i = 0; i < 4; i++) send(d, ca[d][i], cb[d][i], cc[i], 1'b0);
    drain(d);
    check({nm[d], ".carry_count"}, got[d].size() - base, 4);
    if (got[d].size() >= base + 4)
      for (int i = 0; i < 4; i++) check({nm[d], ".carry_val"}, got[d][base + i], ce[d][i]);
  endtask

`ifdef ADDER_PIPE_SUB_EN
  task automatic sub_test(input int d);
    int unsigned base;
    logic [64:0] e1;
    logic [64:0] e2;
    base = got[d].size();
    e1 = (d == 0) ? 65'h1_00000002 : 65'h1_0000000000000002;
    e2 = (d == 0) ? 65'h0_FFFFFFFE : 65'h0_FFFFFFFFFFFFFFFE;
    send(d, 64'd7, 64'd5, 1'b0, 1'b1);
    send(d, 64'd5, 64'd7, 1'b1, 1'b1);
    drain(d);
    check({nm[d], ".sub_count"}, got[d].size() - base, 2);
    if (got[d].size() >= base + 2) begin
      check({nm[d], ".sub_7m5"}, got[d][base], e1);
      check({nm[d], ".sub_5m7"}, got[d][base + 1], e2);
    end
  endtask
`endif

  task automatic bp_test(input int d);
    int unsigned base;
    int unsigned n;
    base = got[d].size();
    set_or(d, 1'b0);
    fork
      begin
        send(d, 64'd1, 64'd1, 1'b0, 1'b0);
        send(d, 64'd2, 64'd2, 1'b0, 1'b0);
        send(d, 64'd3, 64'd3, 1'b0, 1'b0);
      end
      begin
        n = 0;
        @(negedge clock);
        while (!f_ov(d) && n < 40) begin
          @(negedge clock);
          n++;
        end
        check({nm[d], ".bp_in_ready"}, f_ir(d), 0);
        repeat (3) begin
          @(negedge clock);
          check({nm[d], ".bp_hold_valid"}, f_ov(d), 1);
          check({nm[d], ".bp_hold_sum"}, f_sum(d), 65'd2);
        end
        @(posedge clock); #1;
        set_or(d, 1'b1);
      end
    join
    drain(d);
    check({nm[d], ".bp_count"}, got[d].size() - base, 3);
    if (got[d].size() >= base + 3)
      for (int i = 0; i < 3; i++) check({nm[d], ".bp_order"}, got[d][base + i], 65'(2 * (i + 1)));
  endtask

  function automatic logic [63:0] pat();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 64'h0000FFFF0000FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic rnd(input int d);
    bit s;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      set_or(d, $urandom_range(0, 3) != 0);
`ifdef ADDER_PIPE_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      drive(d, $urandom_range(0, 3) != 0, pat(), pat(), 1'($urandom_range(0, 1)), s);
    end
    @(posedge clock); #1;
    drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    set_or(d, 1'b1);
    drain(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      set_or(d, 1'b1);
    end
    repeat (2) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        check({nm[d], ".rst_out_valid"}, f_ov(d), 0);
        check({nm[d], ".rst_out_sum"}, f_sum(d), 0);
        check({nm[d], ".rst_in_ready"}, f_ir(d), 1);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      lat_test(d);
      carry_test(d);
`ifdef ADDER_PIPE_SUB_EN
      sub_test(d);
`endif
      bp_test(d);
    end

    // Two results in flight in each instance, then an asynchronous reset.
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 64'd100, 64'd200, 1'b0, 1'b0);
    @(posedge clock); #1;
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 64'd300, 64'd400, 1'b0, 1'b0);
    @(posedge clock); #1;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    check({nm[0], ".pre_reset_valid"}, f_ov(0), 1);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check({nm[d], ".mid_rst_valid"}, f_ov(d), 0);
      check({nm[d], ".mid_rst_sum"}, f_sum(d), 0);
      check({nm[d], ".mid_rst_ready"}, f_ir(d), 1);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (10) @(negedge clock);
    for (int d = 0; d < 2; d++) check({nm[d], ".post_rst_valid"}, f_ov(d), 0);
    @(posedge clock); #1;

    fork
      rnd(0);
      rnd(1);
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
